rfid_xtea_core: RTL and testbench

RFID_XTEA_CORE -- requirements
Module: rfid_xtea_core

---
 rtl/rfid_pkg.sv | 29 ++
 rtl/rfid_xtea_round.sv | 24 ++
 rtl/rfid_xtea_core.sv | 147 ++++++++++++++
 tb/tb_rfid_xtea_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// Shared types and constants for the RFID XTEA encryption core.
// The core's optional two-cycles-per-clock mode is selected by RFID_XTEA_UNROLL2_EN.
package rfid_pkg;

    typedef logic [31:0] word_t;

    localparam word_t XTEA_DELTA  = 32'h9E37_79B9;
    localparam int    XTEA_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    // k[0] sits in the most significant word of the 128-bit key.
    function automatic word_t key_word(input logic [127:0] key, input logic [1:0] idx);
        word_t w;
        case (idx)
            2'd0:    w = key[127:96];
            2'd1:    w = key[95:64];
            2'd2:    w = key[63:32];
            default: w = key[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rfid_xtea_round.sv
// One full XTEA cycle (both Feistel halves) as pure combinational logic.
module rfid_xtea_round
    import rfid_pkg::*;
(
    input  word_t        v0,
    input  word_t        v1,
    input  word_t        sum,
    input  logic [127:0] key,
    output word_t        v0_next,
    output word_t        v1_next,
    output word_t        sum_next
);

    word_t mix0;
    word_t mix1;

    // The second half uses the already-updated v0 and sum.
    assign mix0     = ((v1 << 4) ^ (v1 >> 5)) + v1;
    assign v0_next  = v0 + (mix0 ^ (sum + key_word(key, sum[1:0])));
    assign sum_next = sum + XTEA_DELTA;
    assign mix1     = ((v0_next << 4) ^ (v0_next >> 5)) + v0_next;
    assign v1_next  = v1 + (mix1 ^ (sum_next + key_word(key, sum_next[12:11])));

endmodule

// File: rtl/rfid_xtea_core.sv
// Two-block XTEA encryptor: block A then block B, started by load falling.
// Define RFID_XTEA_UNROLL2_EN to run two XTEA cycles per clock (half latency).
module rfid_xtea_core
    import rfid_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] cyphertext,
    output logic         done
);

`ifdef RFID_XTEA_UNROLL2_EN
    localparam int CYCLES_PER_CLK = 2;
`else
    localparam int CYCLES_PER_CLK = 1;
`endif
    localparam int         STEPS     = XTEA_CYCLES / CYCLES_PER_CLK;
    localparam logic [4:0] STEP_LAST = 5'(STEPS - 1);

    state_t       state_reg;
    state_t       state_next;
    logic [4:0]   cnt_reg;
    word_t        v0_reg;
    word_t        v1_reg;
    word_t        sum_reg;
    logic [127:0] key_reg;
    logic [63:0]  blk_b_reg;
    logic [63:0]  res_a_reg;
    logic [127:0] cyphertext_reg;
    logic         done_reg;
    logic         last;

    word_t chain_v0  [0:CYCLES_PER_CLK];
    word_t chain_v1  [0:CYCLES_PER_CLK];
    word_t chain_sum [0:CYCLES_PER_CLK];

    assign chain_v0[0]  = v0_reg;
    assign chain_v1[0]  = v1_reg;
    assign chain_sum[0] = sum_reg;

    // Round instances are chained so the unrolled build simply feeds one into the next.
    generate
        for (genvar gi = 0; gi < CYCLES_PER_CLK; gi++) begin : g_round
            rfid_xtea_round u_round (
                .v0       (chain_v0[gi]),
                .v1       (chain_v1[gi]),
                .sum      (chain_sum[gi]),
                .key      (key_reg),
                .v0_next  (chain_v0[gi+1]),
                .v1_next  (chain_v1[gi+1]),
                .sum_next (chain_sum[gi+1])
            );
        end
    endgenerate

    assign last = (cnt_reg == STEP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (!load) state_next = RUN_A;
            RUN_A:   if (load) state_next = IDLE;
                     else if (last) state_next = RUN_B;
            RUN_B:   if (load) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    if (load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            v0_reg         <= '0;
            v1_reg         <= '0;
            sum_reg        <= '0;
            key_reg        <= '0;
            blk_b_reg      <= '0;
            res_a_reg      <= '0;
            cyphertext_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (!load) begin
                        key_reg   <= key;
                        v0_reg    <= plaintext[127:96];
                        v1_reg    <= plaintext[95:64];
                        blk_b_reg <= plaintext[63:0];
                        sum_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                RUN_A: begin
                    if (!load) begin
                        if (last) begin
                            res_a_reg <= {chain_v0[CYCLES_PER_CLK], chain_v1[CYCLES_PER_CLK]};
                            v0_reg    <= blk_b_reg[63:32];
                            v1_reg    <= blk_b_reg[31:0];
                            sum_reg   <= '0;
                            cnt_reg   <= '0;
                        end else begin
                            v0_reg    <= chain_v0[CYCLES_PER_CLK];
                            v1_reg    <= chain_v1[CYCLES_PER_CLK];
                            sum_reg   <= chain_sum[CYCLES_PER_CLK];
                            cnt_reg   <= cnt_reg + 5'd1;
                        end
                    end
                end
                RUN_B: begin
                    if (!load) begin
                        if (last) begin
                            cyphertext_reg <= {res_a_reg, chain_v0[CYCLES_PER_CLK],
                                               chain_v1[CYCLES_PER_CLK]};
                            done_reg       <= 1'b1;
                        end else begin
                            v0_reg  <= chain_v0[CYCLES_PER_CLK];
                            v1_reg  <= chain_v1[CYCLES_PER_CLK];
                            sum_reg <= chain_sum[CYCLES_PER_CLK];
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (load) done_reg <= 1'b0;
                end
                default: done_reg <= 1'b0;
            endcase
        end
    end

    assign cyphertext = cyphertext_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_rfid_xtea_core.sv
// Scoreboard bench for rfid_xtea_core: expected cyphertexts queued at start, checked at done.
module tb_rfid_xtea_core;

`ifdef RFID_XTEA_UNROLL2_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif
    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT1  = 128'h41424344454647484142434445464748;
    localparam logic [127:0] CT1  = 128'h497DF3D072612CB5497DF3D072612CB5;
    localparam logic [127:0] CT0  = 128'hDEE9D4D8F7131ED9DEE9D4D8F7131ED9;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic [127:0] cyphertext;
    logic         done;

    logic [127:0] exp_q[$];
    int assertions = 0;
    int failures   = 0;

    rfid_xtea_core dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .key        (key),
        .plaintext  (plaintext),
        .cyphertext (cyphertext),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xtea_model(input logic [127:0] k, input logic [63:0] blk);
        logic [31:0] kw [4];
        logic [31:0] v0, v1, s;
        for (int j = 0; j < 4; j++) kw[j] = k[127 - 32*j -: 32];
        v0 = blk[63:32];
        v1 = blk[31:0];
        s  = 32'h0;
        for (int i = 0; i < 32; i++) begin
            v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw[s[1:0]]));
            s  = s + 32'h9E3779B9;
            v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw[s[12:11]]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Returns FSM to IDLE, applies operands, drops load; the next edge is edge 1.
    task automatic start_run(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] exp_ct);
        load = 1'b1;
        @(posedge clk); #1;
        key       = k;
        plaintext = pt;
        exp_q.push_back(exp_ct);
        load      = 1'b0;
    endtask

    task automatic wait_done(input int mutate_at, output int edges, output bit early, output bit timeout);
        logic [127:0] prev;
        prev    = cyphertext;
        edges   = 0;
        early   = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            edges++;
            if (edges == mutate_at) begin
                key       = rand128();
                plaintext = rand128();
            end
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (cyphertext !== prev) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; key = '0; plaintext = '0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        assertions++;
        if (cyphertext !== '0) begin failures++; $display("FAIL reset_ct: got %h expected 0", cyphertext); end
        reset = 1'b0;
        $display("reset: done=%b ct=%h", done, cyphertext);
    endtask

    task automatic test_known_vector();
        int edges; bit early, timeout; logic [127:0] exp_ct;
        start_run(KEY1, PT1, CT1);
        wait_done(-1, edges, early, timeout);
        exp_ct = exp_q.pop_front();
        assertions++;
        if (timeout || edges != LAT) begin failures++; $display("FAIL vec_latency: got %0d expected %0d", edges, LAT); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL vec_ct: got %h expected %h", cyphertext, exp_ct); end
        assertions++;
        if (early) begin failures++; $display("FAIL vec_early_ct: got changed expected stable"); end
        $display("known_vector: edges=%0d ct=%h", edges, cyphertext);
    endtask

    task automatic test_hold_release();
        int edges; bit early, timeout; logic [127:0] exp_ct;
        start_run('0, '0, CT0);
        wait_done(-1, edges, early, timeout);
        exp_ct = exp_q.pop_front();
        assertions++;
        if (timeout || edges != LAT) begin failures++; $display("FAIL zero_latency: got %0d expected %0d", edges, LAT); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL zero_ct: got %h expected %h", cyphertext, exp_ct); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            assertions++;
            if (done !== 1'b1 || cyphertext !== exp_ct) begin
                failures++; $display("FAIL hold: got done=%b ct=%h expected done=1 ct=%h", done, cyphertext, exp_ct);
            end
        end
        load = 1'b1;
        @(posedge clk); #1;
        assertions++;
        if (done !== 1'b0) begin failures++; $display("FAIL release_done: got %b expected 0", done); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL release_ct: got %h expected %h", cyphertext, exp_ct); end
        $display("hold_release: done=%b ct=%h", done, cyphertext);
    endtask

    task automatic test_abort();
        int edges; bit early, timeout, saw_done; logic [127:0] exp_ct;
        int abort_at;
        abort_at = (LAT > 40) ? 40 : LAT / 2;
        saw_done = 1'b0;
        start_run(KEY1, PT1, CT1);
        void'(exp_q.pop_back());
        for (int i = 1; i <= abort_at; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            assertions++;
            if (cyphertext !== CT0) begin failures++; $display("FAIL abort_ct: got %h expected %h", cyphertext, CT0); end
        end
        assertions++;
        if (saw_done) begin failures++; $display("FAIL abort_done: got 1 expected 0"); end
        start_run(KEY1, PT1, CT1);
        wait_done(-1, edges, early, timeout);
        exp_ct = exp_q.pop_front();
        assertions++;
        if (timeout || edges != LAT) begin failures++; $display("FAIL restart_latency: got %0d expected %0d", edges, LAT); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL restart_ct: got %h expected %h", cyphertext, exp_ct); end
        $display("abort: at=%0d restart edges=%0d ct=%h", abort_at, edges, cyphertext);
    endtask

    task automatic test_reset_mid_run();
        int edges; bit early, timeout; logic [127:0] k, pt, exp_ct;
        k = rand128(); pt = rand128();
        start_run(k, pt, {xtea_model(k, pt[127:64]), xtea_model(k, pt[63:0])});
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        assertions++;
        if (done !== 1'b0) begin failures++; $display("FAIL async_reset_done: got %b expected 0", done); end
        assertions++;
        if (cyphertext !== '0) begin failures++; $display("FAIL async_reset_ct: got %h expected 0", cyphertext); end
        load = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        k = rand128(); pt = rand128();
        start_run(k, pt, {xtea_model(k, pt[127:64]), xtea_model(k, pt[63:0])});
        wait_done(-1, edges, early, timeout);
        exp_ct = exp_q.pop_front();
        assertions++;
        if (timeout || edges != LAT) begin failures++; $display("FAIL post_reset_latency: got %0d expected %0d", edges, LAT); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL post_reset_ct: got %h expected %h", cyphertext, exp_ct); end
        $display("reset_mid_run: edges=%0d ct=%h", edges, cyphertext);
    endtask

    task automatic test_operand_change();
        int edges; bit early, timeout; logic [127:0] k, pt, exp_ct;
        k = rand128(); pt = rand128();
        start_run(k, pt, {xtea_model(k, pt[127:64]), xtea_model(k, pt[63:0])});
        wait_done(LAT - 10, edges, early, timeout);
        exp_ct = exp_q.pop_front();
        assertions++;
        if (timeout || edges != LAT) begin failures++; $display("FAIL opchg_latency: got %0d expected %0d", edges, LAT); end
        assertions++;
        if (cyphertext !== exp_ct) begin failures++; $display("FAIL opchg_ct: got %h expected %h", cyphertext, exp_ct); end
        $display("operand_change: edges=%0d ct=%h", edges, cyphertext);
    endtask

    task automatic test_back_to_back();
        int edges; bit early, timeout; logic [127:0] k, pt, exp_ct;
        for (int n = 0; n < 4; n++) begin
            k = rand128(); pt = rand128();
            start_run(k, pt, {xtea_model(k, pt[127:64]), xtea_model(k, pt[63:0])});
            wait_done(-1, edges, early, timeout);
            exp_ct = exp_q.pop_front();
            assertions++;
            if (timeout || edges != LAT) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", n, edges, LAT); end
            assertions++;
            if (cyphertext !== exp_ct) begin failures++; $display("FAIL b2b_ct[%0d]: got %h expected %h", n, cyphertext, exp_ct); end
            assertions++;
            if (early) begin failures++; $display("FAIL b2b_early_ct[%0d]: got changed expected stable", n); end
            $display("back_to_back[%0d]: key=%h pt=%h ct=%h", n, k, pt, cyphertext);
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_hold_release();
        test_abort();
        test_reset_mid_run();
        test_operand_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
